scoreboard_hazard_ctrl: RTL

Scoreboard-based hazard controller for the 5-stage non-forwarding RV32I pipeline (IF/ID/EX/MEM/WB); drop-in replacement for the combinational comparator hazard unit. Keeps a per-register countdown of cycles until a pending write is readable from the register file. Drives PC enable, IF/ID enable and the IF/ID and ID/EX flush controls. Counts stall and flush cycles for debug.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/scoreboard_hazard_ctrl_sb_cnt_array.sv | 47 ++++
 rtl/scoreboard_hazard_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the scoreboard hazard controller.
//   NUM_REGS        architectural integer registers (x0..x31)
//   REG_AW          register address width
//   PEND_CNT_W      width of one scoreboard countdown entry
//   PEND_CYCLES_DEF default countdown load value
//   pend_cnt_t      type of one countdown entry
//   ctrl_mode_t     pipeline control decision for the current cycle
package hazard_pkg;

    localparam int unsigned NUM_REGS        = 32;
    localparam int unsigned REG_AW          = 5;
    localparam int unsigned PEND_CNT_W      = 3;
    localparam int unsigned PEND_CYCLES_DEF = 3;

    typedef logic [PEND_CNT_W-1:0] pend_cnt_t;

    typedef enum logic [1:0] {
        CTRL_NORMAL,
        CTRL_STALL,
        CTRL_REDIRECT
    } ctrl_mode_t;

endpackage

// File: rtl/scoreboard_hazard_ctrl_sb_cnt_array.sv
// Scoreboard countdown array: one entry per register x1..x31 holding the
// number of cycles until a pending write becomes readable from the regfile.
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset, clears every entry
//   i_set_en    load entry i_set_addr with PEND_CYCLES this edge
//   i_set_addr  register whose entry is loaded
//   o_busy      bit r set while entry r is non-zero; bit 0 always 0
module sb_cnt_array
    import hazard_pkg::*;
#(
    parameter int unsigned PEND_CYCLES = PEND_CYCLES_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_set_en,
    input  logic [REG_AW-1:0] i_set_addr,
    output logic [NUM_REGS-1:0] o_busy
);

    pend_cnt_t cnt [1:NUM_REGS-1];

    // A set on an entry that is also counting down takes the reload: the
    // younger producer writes back later, so its latency is the one to keep.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (i_set_en && (i_set_addr == REG_AW'(r))) begin
                    cnt[r] <= pend_cnt_t'(PEND_CYCLES);
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - pend_cnt_t'(1);
                end
            end
        end
    end

    always_comb begin
        o_busy = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            o_busy[r] = (cnt[r] != '0);
        end
    end

endmodule

// File: rtl/scoreboard_hazard_ctrl.sv
// Scoreboard-based hazard controller for a 5-stage non-forwarding pipeline.
// Stalls an ID instruction whose sources have pending writes, flushes on an
// EX redirect, and counts stall/flush cycles.
//   i_clk, i_rst_n                 clock / async active-low reset
//   i_id_vld                       ID holds a valid instruction
//   i_id_rs1_addr/_used            rs1 of ID instruction and whether it is read
//   i_id_rs2_addr/_used            rs2 of ID instruction and whether it is read
//   i_id_rd_addr/_wren             rd of ID instruction and whether it is written
//   i_ex_br_taken                  EX redirect this cycle
//   o_pc_en, o_ifid_en             PC / IF-ID load enables
//   o_ifid_flush, o_idex_flush     bubble IF-ID / ID-EX on next edge
//   o_busy_mask                    per-register pending-write flags
//   o_stall_cnt, o_flush_cnt       saturating stall / redirect cycle counters
module scoreboard_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned PEND_CYCLES = PEND_CYCLES_DEF,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_id_vld,
    input  logic [REG_AW-1:0] i_id_rs1_addr,
    input  logic [REG_AW-1:0] i_id_rs2_addr,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    input  logic [REG_AW-1:0] i_id_rd_addr,
    input  logic              i_id_rd_wren,
    input  logic              i_ex_br_taken,
    output logic              o_pc_en,
    output logic              o_ifid_en,
    output logic              o_ifid_flush,
    output logic              o_idex_flush,
    output logic [NUM_REGS-1:0] o_busy_mask,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    logic [NUM_REGS-1:0] busy;
    logic                haz;
    logic                issue;
    logic                set_en;
    ctrl_mode_t          mode;

    sb_cnt_array #(
        .PEND_CYCLES (PEND_CYCLES)
    ) u_cnt_array (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_set_en   (set_en),
        .i_set_addr (i_id_rd_addr),
        .o_busy     (busy)
    );

    // Hazard looks only at the pre-issue scoreboard, so an instruction that
    // reads its own destination never stalls on itself.
    always_comb begin
        haz = i_id_vld &
              ((i_id_rs1_used & (i_id_rs1_addr != '0) & busy[i_id_rs1_addr]) |
               (i_id_rs2_used & (i_id_rs2_addr != '0) & busy[i_id_rs2_addr]));
        issue  = i_id_vld & ~haz & ~i_ex_br_taken;
        set_en = issue & i_id_rd_wren & (i_id_rd_addr != '0);
    end

    always_comb begin
        mode = CTRL_NORMAL;
        if (i_ex_br_taken) begin
            mode = CTRL_REDIRECT;
        end else if (haz) begin
            mode = CTRL_STALL;
        end
    end

    always_comb begin
        o_pc_en      = 1'b1;
        o_ifid_en    = 1'b1;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        case (mode)
            CTRL_STALL: begin
                o_pc_en      = 1'b0;
                o_ifid_en    = 1'b0;
                o_idex_flush = 1'b1;
            end
            CTRL_REDIRECT: begin
                o_ifid_flush = 1'b1;
                o_idex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_busy_mask = busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            if ((mode == CTRL_STALL) && (o_stall_cnt != '1)) begin
                o_stall_cnt <= o_stall_cnt + CNT_W'(1);
            end
            if ((mode == CTRL_REDIRECT) && (o_flush_cnt != '1)) begin
                o_flush_cnt <= o_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
